// File: rtl/cla_nibble_serial_adder.sv
// Purpose: WIDTH-bit adder that reuses one 4-bit carry-lookahead nibble slice, LSB nibble first.
// Latency: accept at edge T0 -> out_valid high after edge T0+WIDTH/4; one op per WIDTH/4+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready, no op overlap.
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;       // operand A, shifted right one nibble per RUN edge
    logic [WIDTH-1:0] b_q;       // operand B, shifted right one nibble per RUN edge
    logic [WIDTH-5:0] sum_q;     // nibbles produced so far, filled from the top
    logic             c_q;       // carry into the current nibble
    logic [CW-1:0]    cnt;       // index of the nibble being added

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       gen;
    logic [3:0]       prop;
    logic             c1;
    logic             c2;
    logic             c3;        // carry into bit 3 of the nibble (MSB carry-in on the last nibble)
    logic             c4;        // nibble carry-out
    logic [3:0]       nib_s;
    logic [WIDTH-1:0] sum_next;  // current nibble on top of the earlier ones

    // 4-bit generate/propagate lookahead on the current low nibble of the operands
    always_comb begin
        nib_a = a_q[3:0];
        nib_b = b_q[3:0];
        gen   = nib_a & nib_b;
        prop  = nib_a ^ nib_b;
        c1    = gen[0] | (prop[0] & c_q);
        c2    = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_q);
        c3    = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & c_q);
        c4    = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
              | (prop[3] & prop[2] & prop[1] & gen[0])
              | (prop[3] & prop[2] & prop[1] & prop[0] & c_q);
        nib_s    = prop ^ {c3, c2, c1, c_q};
        sum_next = {nib_s, sum_q};
    end

    // Control FSM plus datapath registers; all outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_s        <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            c_q          <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        c_q      <= in_carry;
                        sum_q    <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= {4'b0000, a_q[WIDTH-1:4]};
                    b_q   <= {4'b0000, b_q[WIDTH-1:4]};
                    sum_q <= sum_next[WIDTH-1:4];
                    c_q   <= c4;
                    if (cnt == CW'(NIB - 1)) begin
                        // Last nibble: publish the full result, overflow from MSB carry-in vs carry-out
                        out_s        <= sum_next;
                        out_carry    <= c4;
                        out_overflow <= c3 ^ c4;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Purpose: randomized and directed bench for cla_nibble_serial_adder with a queue scoreboard.
// Latency: expects out_valid WIDTH/4 edges after each accept.
// Backpressure: exercises held results, blocked accepts, mid-op reset and back-to-back ops.
module tb_cla_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_carry;
    logic         out_overflow;

    typedef struct packed {
        logic         ovf;
        logic         carry;
        logic [W-1:0] s;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   total     = 0;
    int   bad       = 0;
    int   n_results = 0;
    bit   rand_bp   = 1'b0;

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_carry     (in_carry),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_s        (out_s),
        .out_carry    (out_carry),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer addition, signed overflow from the range of the signed sum
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        res_t       r;
        logic [W:0] full;
        longint     ssum;
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r.s     = full[W-1:0];
        r.carry = full[W];
        ssum    = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        r.ovf   = (ssum > ((longint'(1) <<< (W - 1)) - 1)) || (ssum < -(longint'(1) <<< (W - 1)));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result handshake pops the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result: unexpected output s=%h none expected", out_s);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", 32'({out_overflow, out_carry, out_s}), 32'(mon_e));
            end
        end
    end

    // Random consumer backpressure when enabled
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present an operand, wait for the accept edge, then scramble inputs to prove one-time sampling
    task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int t = 0;
        in_a     = a;
        in_b     = b;
        in_carry = ci;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept: in_ready=%b after %0d cycles, want 1", in_ready, t);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model(a, b, ci));
        #1;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_carry = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        do_accept(a, b, ci);
        wait_valid(n);
        chk("latency", 32'(n), 32'd4);
        chk("sum", 32'(out_s), 32'(es));
        chk("carry_ovf", 32'({out_carry, out_overflow}), 32'({ec, eo}));
        wait_drain();
    endtask

    initial begin
        int           n;
        int           r0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_s", 32'(out_s), 32'd0);
        chk("rst_flags", 32'({out_carry, out_overflow}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("in_ready_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_post_edge", 32'(in_ready), 32'd1);

        // Directed arithmetic cases
        out_ready = 1'b1;
        run_vec(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_vec(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_vec(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_vec(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_vec(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result held in DONE while a new operand waits
        out_ready = 1'b0;
        do_accept(16'hABCD, 16'h1111, 1'b1);
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'd4);
        in_a     = 16'h0F0F;
        in_b     = 16'h0101;
        in_carry = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_s", 32'(out_s), 32'h0000BCDF);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        do_accept(16'h0F0F, 16'h0101, 1'b0);
        wait_drain();

        // Reset in the middle of RUN aborts the operation
        r0 = n_results;
        do_accept(16'h1111, 16'h2222, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_s", 32'(out_s), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_no_result", 32'(n_results - r0), 32'd0);
        run_vec(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Back-to-back: in_valid stays high across two operand sets
        r0 = n_results;
        do_accept(16'h00FF, 16'h0F01, 1'b0);
        do_accept(16'h9000, 16'hA000, 1'b1);
        wait_drain();
        chk("b2b_count", 32'(n_results - r0), 32'd2);

        // Random operands with random consumer stalls
        rand_bp = 1'b1;
        r0 = n_results;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h7FFF;
                1: rb = 16'h8000;
                2: ra = 16'hFFFF;
                default: ;
            endcase
            do_accept(ra, rb, 1'($urandom_range(0, 1)));
        end
        wait_drain();
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("rand_count", 32'(n_results - r0), 32'd40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
